// File: rtl/instr_register_alu.sv
// instr_register_alu: DEPTH-entry instruction register. Each write is computed
// one cycle after capture and stored together with its result and error flag.
// Reads are registered, with a one-cycle valid strobe. A read of the slot being
// committed in the same cycle returns the new data.
module instr_register_alu #(
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned OP_WIDTH = 32
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              load_en,
   input  logic [3:0]                        opcode,
   input  logic signed [OP_WIDTH-1:0]        operand_a,
   input  logic signed [OP_WIDTH-1:0]        operand_b,
   input  logic [$clog2(DEPTH)-1:0]          write_pointer,
   input  logic                              read_en,
   input  logic [$clog2(DEPTH)-1:0]          read_pointer,
   output logic                              instr_valid,
   output logic [3:0]                        instr_opcode,
   output logic signed [OP_WIDTH-1:0]        instr_operand_a,
   output logic signed [OP_WIDTH-1:0]        instr_operand_b,
   output logic signed [2*OP_WIDTH-1:0]      instr_result,
   output logic                              instr_err,
   output logic                              instr_written
);

   localparam int unsigned AW        = $clog2(DEPTH);
   localparam int unsigned RES_WIDTH = 2 * OP_WIDTH;

   localparam logic [3:0] OP_ZERO  = 4'd0;
   localparam logic [3:0] OP_PASSA = 4'd1;
   localparam logic [3:0] OP_PASSB = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_MULT  = 4'd5;
   localparam logic [3:0] OP_DIV   = 4'd6;
   localparam logic [3:0] OP_MOD   = 4'd7;

   // Stage register between capture and commit
   logic                       s1_valid;
   logic [3:0]                 s1_opcode;
   logic signed [OP_WIDTH-1:0] s1_a;
   logic signed [OP_WIDTH-1:0] s1_b;
   logic [AW-1:0]              s1_ptr;

   // Slot storage
   logic [3:0]                  mem_opcode [DEPTH];
   logic signed [OP_WIDTH-1:0]  mem_a      [DEPTH];
   logic signed [OP_WIDTH-1:0]  mem_b      [DEPTH];
   logic signed [RES_WIDTH-1:0] mem_res    [DEPTH];
   logic [DEPTH-1:0]            mem_err;
   logic [DEPTH-1:0]            mem_written;

   logic signed [RES_WIDTH-1:0] a_ext_c;
   logic signed [RES_WIDTH-1:0] b_ext_c;
   logic signed [RES_WIDTH-1:0] res_c;
   logic                        err_c;
   logic                        fwd_c;

   // Capture a load request into the stage register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid  <= 1'b0;
         s1_opcode <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_ptr    <= '0;
      end else begin
         s1_valid <= load_en;
         if (load_en) begin
            s1_opcode <= opcode;
            s1_a      <= operand_a;
            s1_b      <= operand_b;
            s1_ptr    <= write_pointer;
         end
      end
   end

   // Signed arithmetic at full result width on the staged instruction
   always_comb begin
      a_ext_c = {{OP_WIDTH{s1_a[OP_WIDTH-1]}}, s1_a};
      b_ext_c = {{OP_WIDTH{s1_b[OP_WIDTH-1]}}, s1_b};
      res_c   = '0;
      err_c   = 1'b0;
      case (s1_opcode)
         OP_ZERO:  res_c = '0;
         OP_PASSA: res_c = a_ext_c;
         OP_PASSB: res_c = b_ext_c;
         OP_ADD:   res_c = a_ext_c + b_ext_c;
         OP_SUB:   res_c = a_ext_c - b_ext_c;
         OP_MULT:  res_c = a_ext_c * b_ext_c;
         OP_DIV: begin
            if (s1_b == '0) err_c = 1'b1;
            else            res_c = a_ext_c / b_ext_c;
         end
         OP_MOD: begin
            if (s1_b == '0) err_c = 1'b1;
            else            res_c = a_ext_c % b_ext_c;
         end
         default:  err_c = 1'b1;
      endcase
   end

   // Commit the staged instruction and its result into the slot
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_opcode[i] <= '0;
            mem_a[i]      <= '0;
            mem_b[i]      <= '0;
            mem_res[i]    <= '0;
         end
         mem_err     <= '0;
         mem_written <= '0;
      end else if (s1_valid) begin
         mem_opcode[s1_ptr]  <= s1_opcode;
         mem_a[s1_ptr]       <= s1_a;
         mem_b[s1_ptr]       <= s1_b;
         mem_res[s1_ptr]     <= res_c;
         mem_err[s1_ptr]     <= err_c;
         mem_written[s1_ptr] <= 1'b1;
      end
   end

   // A read of the slot committing this cycle takes the new data directly
   always_comb begin
      fwd_c = s1_valid && (s1_ptr == read_pointer);
   end

   // Registered read port with one-cycle valid strobe; data holds when idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_valid     <= 1'b0;
         instr_opcode    <= '0;
         instr_operand_a <= '0;
         instr_operand_b <= '0;
         instr_result    <= '0;
         instr_err       <= 1'b0;
         instr_written   <= 1'b0;
      end else begin
         instr_valid <= read_en;
         if (read_en) begin
            if (fwd_c) begin
               instr_opcode    <= s1_opcode;
               instr_operand_a <= s1_a;
               instr_operand_b <= s1_b;
               instr_result    <= res_c;
               instr_err       <= err_c;
               instr_written   <= 1'b1;
            end else begin
               instr_opcode    <= mem_opcode[read_pointer];
               instr_operand_a <= mem_a[read_pointer];
               instr_operand_b <= mem_b[read_pointer];
               instr_result    <= mem_res[read_pointer];
               instr_err       <= mem_err[read_pointer];
               instr_written   <= mem_written[read_pointer];
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_register_alu.sv
// Directed bench for instr_register_alu: a vector table of computed results
// plus hand-written hazard, back-to-back and reset sequences.
module tb_instr_register_alu;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               load_en;
   logic [3:0]         opcode;
   logic signed [31:0] operand_a;
   logic signed [31:0] operand_b;
   logic [4:0]         write_pointer;
   logic               read_en;
   logic [4:0]         read_pointer;
   logic               instr_valid;
   logic [3:0]         instr_opcode;
   logic signed [31:0] instr_operand_a;
   logic signed [31:0] instr_operand_b;
   logic signed [63:0] instr_result;
   logic               instr_err;
   logic               instr_written;

   int n_chk  = 0;
   int n_fail = 0;

   instr_register_alu #(.DEPTH(32), .OP_WIDTH(32)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .load_en         (load_en),
      .opcode          (opcode),
      .operand_a       (operand_a),
      .operand_b       (operand_b),
      .write_pointer   (write_pointer),
      .read_en         (read_en),
      .read_pointer    (read_pointer),
      .instr_valid     (instr_valid),
      .instr_opcode    (instr_opcode),
      .instr_operand_a (instr_operand_a),
      .instr_operand_b (instr_operand_b),
      .instr_result    (instr_result),
      .instr_err       (instr_err),
      .instr_written   (instr_written)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]         op;
      logic signed [31:0] a;
      logic signed [31:0] b;
      logic [4:0]         ptr;
      logic signed [63:0] res;
      logic               err;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_load(input logic [3:0] op, input logic signed [31:0] a,
                           input logic signed [31:0] b, input logic [4:0] ptr);
      load_en       = 1'b1;
      opcode        = op;
      operand_a     = a;
      operand_b     = b;
      write_pointer = ptr;
   endtask

   task automatic read_slot(input logic [4:0] ptr);
      read_en      = 1'b1;
      read_pointer = ptr;
      tick();
      read_en      = 1'b0;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_valid"},   64'(instr_valid), 64'd0);
      chk({tag, "_opcode"},  64'(instr_opcode), 64'd0);
      chk({tag, "_a"},       64'(instr_operand_a), 64'd0);
      chk({tag, "_result"},  64'(instr_result), 64'd0);
      chk({tag, "_err"},     64'(instr_err), 64'd0);
      chk({tag, "_written"}, 64'(instr_written), 64'd0);
   endtask

   initial begin
      vecs[0]  = '{4'd3,  32'sd5,          32'sd7,          5'd0,  64'sd12,          1'b0};
      vecs[1]  = '{4'd5,  -32'sd3,         32'sd2147483647, 5'd1,  -64'sd6442450941, 1'b0};
      vecs[2]  = '{4'd6,  -32'sd7,         32'sd2,          5'd4,  -64'sd3,          1'b0};
      vecs[3]  = '{4'd7,  -32'sd7,         32'sd2,          5'd6,  -64'sd1,          1'b0};
      vecs[4]  = '{4'd6,  32'sd9,          32'sd0,          5'd7,  64'sd0,           1'b1};
      vecs[5]  = '{4'd12, 32'sd9,          32'sd4,          5'd8,  64'sd0,           1'b1};
      vecs[6]  = '{4'd4,  32'sd3,          32'sd10,         5'd9,  -64'sd7,          1'b0};
      vecs[7]  = '{4'd1,  -32'sd100,       32'sd8,          5'd10, -64'sd100,        1'b0};
      vecs[8]  = '{4'd2,  32'sd1,          32'sd55,         5'd11, 64'sd55,          1'b0};
      vecs[9]  = '{4'd0,  32'sd9,          32'sd9,          5'd12, 64'sd0,           1'b0};
      vecs[10] = '{4'd6,  32'sh80000000,   -32'sd1,         5'd13, 64'sd2147483648,  1'b0};
      vecs[11] = '{4'd7,  32'sd7,          32'sd0,          5'd14, 64'sd0,           1'b1};
      vecs[12] = '{4'd7,  32'sd7,          -32'sd2,         5'd15, 64'sd1,           1'b0};
      vecs[13] = '{4'd5,  32'sh80000000,   32'sh80000000,   5'd16, 64'sd4611686018427387904, 1'b0};

      reset_n = 1'b0; load_en = 1'b0; read_en = 1'b0;
      opcode = '0; operand_a = '0; operand_b = '0; write_pointer = '0; read_pointer = '0;
      tick(); tick();
      chk_zero_outputs("por");
      reset_n = 1'b1;

      // table: back-to-back loads, then read each slot back
      for (int i = 0; i < NV; i++) begin
         set_load(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ptr);
         tick();
      end
      load_en = 1'b0;
      tick();
      for (int i = 0; i < NV; i++) begin
         read_slot(vecs[i].ptr);
         chk($sformatf("vec%0d_valid", i),   64'(instr_valid), 64'd1);
         chk($sformatf("vec%0d_opcode", i),  64'(instr_opcode), 64'(vecs[i].op));
         chk($sformatf("vec%0d_a", i),       64'(instr_operand_a), 64'(vecs[i].a));
         chk($sformatf("vec%0d_b", i),       64'(instr_operand_b), 64'(vecs[i].b));
         chk($sformatf("vec%0d_result", i),  64'(instr_result), 64'(vecs[i].res));
         chk($sformatf("vec%0d_err", i),     64'(instr_err), 64'(vecs[i].err));
         chk($sformatf("vec%0d_written", i), 64'(instr_written), 64'd1);
      end

      // hazard on slot 3: old, forwarded, stored
      set_load(4'd3, 32'sd1, 32'sd1, 5'd3);
      tick();
      load_en = 1'b0;
      tick(); tick();
      set_load(4'd4, 32'sd10, 32'sd4, 5'd3);
      read_en = 1'b1; read_pointer = 5'd3;
      tick();
      load_en = 1'b0;
      chk("haz_n_result", 64'(instr_result), 64'd2);
      chk("haz_n_opcode", 64'(instr_opcode), 64'd3);
      tick();
      chk("haz_n1_result", 64'(instr_result), 64'd6);
      chk("haz_n1_opcode", 64'(instr_opcode), 64'd4);
      tick();
      chk("haz_n2_result", 64'(instr_result), 64'd6);
      chk("haz_n2_valid",  64'(instr_valid), 64'd1);
      read_en = 1'b0;
      tick();
      chk("idle_valid",  64'(instr_valid), 64'd0);
      chk("idle_hold",   64'(instr_result), 64'd6);

      // top slot written on consecutive edges: later instruction wins
      set_load(4'd1, 32'sd5, 32'sd0, 5'd31);
      tick();
      set_load(4'd1, 32'sd11, 32'sd0, 5'd31);
      tick();
      set_load(4'd1, 32'sd22, 32'sd0, 5'd31);
      tick();
      load_en = 1'b0;
      read_slot(5'd31);
      chk("b2b_fwd_result", 64'(instr_result), 64'd22);
      read_slot(5'd31);
      chk("b2b_mem_result", 64'(instr_result), 64'd22);
      chk("b2b_mem_a",      64'(instr_operand_a), 64'd22);
      read_slot(5'd20);
      chk("unwritten_valid",   64'(instr_valid), 64'd1);
      chk("unwritten_written", 64'(instr_written), 64'd0);
      chk("unwritten_result",  64'(instr_result), 64'd0);

      // reset between capture and commit of a slot-2 load
      set_load(4'd3, 32'sd3, 32'sd4, 5'd2);
      read_en = 1'b1; read_pointer = 5'd31;
      tick();
      load_en = 1'b0; read_en = 1'b0;
      chk("pre_rst_result", 64'(instr_result), 64'd22);
      reset_n = 1'b0;
      #1;
      chk_zero_outputs("mid_rst");
      tick();
      reset_n = 1'b1;
      tick();
      read_slot(5'd2);
      chk("lost_valid",   64'(instr_valid), 64'd1);
      chk("lost_written", 64'(instr_written), 64'd0);
      chk("lost_result",  64'(instr_result), 64'd0);
      chk("lost_opcode",  64'(instr_opcode), 64'd0);
      read_slot(5'd5);
      chk("slot5_valid",   64'(instr_valid), 64'd1);
      chk("slot5_written", 64'(instr_written), 64'd0);
      chk("slot5_result",  64'(instr_result), 64'd0);
      read_slot(5'd0);
      chk("slot0_cleared_written", 64'(instr_written), 64'd0);
      chk("slot0_cleared_a",       64'(instr_operand_a), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
